act_line_feeder: RTL

- Upstream stage of the depthwise kernel cell. Accepts one raster-order activation pixel per cycle over a valid/ready handshake.
- Holds the DIMY-1 previous image rows in line buffers. Drives the packed vertical column {row r-2, row r-1, row r} at column c onto the kernel cell's act_data input.
- Inserts flush gaps between rows so the kernel cell's horizontal pipeline never mixes pixels from two rows.

---
 rtl/act_line_feeder.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/act_line_feeder.sv
// Line feeder for the depthwise kernel cell: buffers DIMY-1 rows and emits packed vertical columns.
// Define ACT_LINE_FEEDER_PAD_EN to zero-pad the top rows and emit columns during FILL.
module act_line_feeder #(
    parameter int DATA_WIDTH = 8,
    parameter int DIMX       = 3,
    parameter int DIMY       = 3,
    parameter int IMG_W      = 32,
    parameter int IMG_H      = 32,
    parameter int COL_W      = $clog2(IMG_W),
    parameter int ROW_W      = $clog2(IMG_H)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_WIDTH-1:0]      in_data,
    output logic [DIMY*DATA_WIDTH-1:0] act_data,
    output logic                       act_valid,
    output logic [ROW_W-1:0]           row_idx,
    output logic [COL_W-1:0]           col_idx,
    output logic                       frame_done
);

`ifdef ACT_LINE_FEEDER_PAD_EN
    localparam bit PAD_EN = 1'b1;
`else
    localparam bit PAD_EN = 1'b0;
`endif

    localparam int LB_N  = (DIMY > 1) ? DIMY - 1 : 1;
    localparam int GAP_W = (DIMX > 2) ? $clog2(DIMX - 1) : 1;

    // state  | meaning
    // IDLE   | waiting for pixel (0,0)
    // FILL   | priming line buffers, rows 0..DIMY-2
    // STREAM | emitting full columns
    // GAP    | DIMX-1 flush cycles between rows
    // DONE   | frame complete pulse
    typedef enum logic [2:0] {IDLE, FILL, STREAM, GAP, DONE} state_t;

    state_t                    state, state_nxt;
    logic [COL_W-1:0]          col;
    logic [ROW_W-1:0]          row;
    logic [GAP_W-1:0]          gap_cnt;
    logic                      accept;
    logic                      last_col;
    logic                      last_row;
    logic                      row_emits;
    logic                      out_valid_nxt;
    logic [DIMY*DATA_WIDTH-1:0] col_word;
    logic [DATA_WIDTH-1:0]     lb [LB_N][IMG_W];

    assign in_ready   = ~reset & (state == IDLE || state == FILL || state == STREAM);
    assign frame_done = (state == DONE);
    assign accept     = in_valid & in_ready;
    assign last_col   = (col == COL_W'(IMG_W - 1));
    assign last_row   = (row == ROW_W'(IMG_H - 1));
    assign row_emits  = PAD_EN || (int'(row) >= DIMY - 1);
    assign out_valid_nxt = accept & row_emits;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept)
                    state_nxt = (DIMY == 1) ? STREAM : FILL;
            end
            FILL, STREAM: begin
                if (accept && last_col) begin
                    if (last_row)
                        state_nxt = DONE;
                    else if (row_emits && DIMX > 1)
                        state_nxt = GAP;
                    else
                        state_nxt = (int'(row) >= DIMY - 2) ? STREAM : FILL;
                end
            end
            GAP: begin
                // row has already advanced to the row about to start
                if (gap_cnt == '0)
                    state_nxt = (int'(row) >= DIMY - 1) ? STREAM : FILL;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        col_word = '0;
        col_word[DATA_WIDTH-1:0] = in_data;
        for (int k = 1; k < DIMY; k++) begin
            if (!PAD_EN || int'(row) >= k)
                col_word[k*DATA_WIDTH +: DATA_WIDTH] = lb[k-1][col];
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            lb[0][col] <= in_data;
            for (int k = 1; k < LB_N; k++)
                lb[k][col] <= lb[k-1][col];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            col       <= '0;
            row       <= '0;
            gap_cnt   <= '0;
            act_data  <= '0;
            act_valid <= 1'b0;
            row_idx   <= '0;
            col_idx   <= '0;
        end else begin
            state <= state_nxt;
            if (state == DONE) begin
                col <= '0;
                row <= '0;
            end else if (accept) begin
                if (last_col) begin
                    col <= '0;
                    row <= last_row ? '0 : row + ROW_W'(1);
                end else begin
                    col <= col + COL_W'(1);
                end
            end
            if (state_nxt == GAP && state != GAP)
                gap_cnt <= GAP_W'(DIMX - 2);
            else if (state == GAP)
                gap_cnt <= gap_cnt - GAP_W'(1);
            act_valid <= out_valid_nxt;
            act_data  <= out_valid_nxt ? col_word : '0;
            if (out_valid_nxt) begin
                row_idx <= row;
                col_idx <= col;
            end
        end
    end

endmodule
